// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised single-clock FIFO.
// Optional sticky error flags are enabled with SYNC_FIFO_ERR_FLAGS_EN.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    // almost_full default sits this many entries below depth
    localparam int DEFAULT_AF_MARGIN = 2;
    localparam int DEFAULT_AE_THRESH = 2;

    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array is never reset; only the read register clears on rst.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with thresholds, fill count and read strobe.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH          = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH          = DEFAULT_ADDR_WIDTH,
    parameter int ALMOST_FULL_THRESH  = (2 ** ADDR_WIDTH) - DEFAULT_AF_MARGIN,
    parameter int ALMOST_EMPTY_THRESH = DEFAULT_AE_THRESH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH-1:0]              write_data,
    input  logic                               write_enable,
    input  logic                               read_enable,
    output logic [DATA_WIDTH-1:0]              read_data,
    output logic                               read_valid,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic                               almost_empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output logic                               overflow,
    output logic                               underflow,
`endif
    output logic [count_width(ADDR_WIDTH)-1:0] fill_count
);

    localparam int CW = count_width(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(1 << ADDR_WIDTH);
    localparam logic [CW-1:0] AF_T    = CW'(ALMOST_FULL_THRESH);
    localparam logic [CW-1:0] AE_T    = CW'(ALMOST_EMPTY_THRESH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  rvalid_q, rvalid_d;
    logic                  wr_acc, rd_acc;

    // Accept decisions use this cycle's registered flags only
    assign wr_acc = write_enable && !full_q;
    assign rd_acc = read_enable && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d   = (count_d == DEPTH_C);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AF_T);
        aempty_d = (count_d <= AE_T);
        rvalid_d = rd_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            rvalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            rvalid_q <= rvalid_d;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc && !rst),
        .wr_addr (wr_ptr_q),
        .wr_data (write_data),
        .rd_en   (rd_acc && !rst),
        .rd_addr (rd_ptr_q),
        .rd_data (read_data)
    );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q || (write_enable && full_q);
        underflow_d = underflow_q || (read_enable && empty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign read_valid   = rvalid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign fill_count   = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param against a queue-based model.
// Error-flag checks compile in when SYNC_FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          write_enable = 1'b0;
    logic          read_enable = 1'b0;
    logic [DW-1:0] read_data;
    logic          read_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   fill_count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd = '0;
    logic          m_rv = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    sync_fifo_param #(
        .DATA_WIDTH          (DW),
        .ADDR_WIDTH          (AW),
        .ALMOST_FULL_THRESH  (AF),
        .ALMOST_EMPTY_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .fill_count   (fill_count)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, apply the FIFO rules to the model, sample at +1
    task automatic cycle(input logic r, input logic we, input logic re,
                         input logic [DW-1:0] wd);
        logic wr_ok;
        logic rd_ok;
        rst = r;
        write_enable = we;
        read_enable = re;
        write_data = wd;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_rd = '0;
            m_rv = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            wr_ok = we && (q.size() < DEPTH);
            rd_ok = re && (q.size() > 0);
            if (we && q.size() == DEPTH) m_ovf = 1'b1;
            if (re && q.size() == 0) m_unf = 1'b1;
            m_rv = rd_ok;
            if (rd_ok) m_rd = q.pop_front();
            if (wr_ok) q.push_back(wd);
        end
        #1;
        rst = 1'b0;
        write_enable = 1'b0;
        read_enable = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_empty got=%b exp=1", empty);
        end
        checks++;
        if (almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_aempty got=%b exp=1", almost_empty);
        end
        checks++;
        if (full !== 1'b0 || almost_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_full got=%b/%b exp=0/0", full, almost_full);
        end
        checks++;
        if (fill_count !== 5'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", fill_count);
        end
        checks++;
        if (read_data !== 8'h00 || read_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rd got=%h/%b exp=00/0", read_data, read_valid);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_err got=%b/%b exp=0/0", overflow, underflow);
        end
`endif
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b0, DW'(i));
            checks++;
            if (fill_count !== 5'(i)) begin
                failures++;
                $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, fill_count, i);
            end
            checks++;
            if (almost_empty !== (i <= AE) || almost_full !== (i >= AF)) begin
                failures++;
                $display("FAIL fill_thresh[%0d] got ae=%b af=%b", i,
                         almost_empty, almost_full);
            end
            checks++;
            if (full !== (i == DEPTH) || empty !== 1'b0) begin
                failures++;
                $display("FAIL fill_flags[%0d] got full=%b empty=%b", i, full, empty);
            end
        end
        cycle(1'b0, 1'b1, 1'b0, 8'hFF);
        checks++;
        if (fill_count !== 5'd16 || full !== 1'b1) begin
            failures++;
            $display("FAIL overfill got=%0d/%b exp=16/1", fill_count, full);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set got=%b exp=1", overflow);
        end
`endif
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
            checks++;
            if (read_valid !== 1'b1 || read_data !== DW'(i)) begin
                failures++;
                $display("FAIL drain[%0d] got=%h/%b exp=%h/1", i, read_data,
                         read_valid, DW'(i));
            end
        end
        checks++;
        if (empty !== 1'b1 || fill_count !== 5'd0) begin
            failures++;
            $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, fill_count);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (read_valid !== 1'b0 || read_data !== 8'h10) begin
            failures++;
            $display("FAIL drain_hold got=%h/%b exp=10/0", read_data, read_valid);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 1; i <= DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, DW'(i));
        cycle(1'b0, 1'b1, 1'b1, 8'hAA);
        checks++;
        if (read_data !== 8'h01 || read_valid !== 1'b1) begin
            failures++;
            $display("FAIL full_rw_rd got=%h/%b exp=01/1", read_data, read_valid);
        end
        checks++;
        if (fill_count !== 5'd15 || full !== 1'b0) begin
            failures++;
            $display("FAIL full_rw_cnt got=%0d/%b exp=15/0", fill_count, full);
        end
        for (int i = 2; i <= DEPTH; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
            checks++;
            if (read_data !== DW'(i)) begin
                failures++;
                $display("FAIL full_rw_drain[%0d] got=%h exp=%h", i, read_data, DW'(i));
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL full_rw_empty got=%b exp=1", empty);
        end
    endtask

    task automatic test_empty_rw();
        cycle(1'b0, 1'b1, 1'b1, 8'h5A);
        checks++;
        if (read_valid !== 1'b0 || fill_count !== 5'd1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL empty_rw got rv=%b cnt=%0d empty=%b exp=0/1/0",
                     read_valid, fill_count, empty);
        end
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (read_data !== 8'h5A || read_valid !== 1'b1) begin
            failures++;
            $display("FAIL empty_rw_next got=%h/%b exp=5a/1", read_data, read_valid);
        end
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (read_valid !== 1'b0 || read_data !== 8'h5A) begin
            failures++;
            $display("FAIL empty_rd got=%h/%b exp=5a/0", read_data, read_valid);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL underflow_set got=%b exp=1", underflow);
        end
`endif
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, DW'($urandom));
        checks++;
        if (fill_count !== 5'd9) begin
            failures++;
            $display("FAIL mid_fill got=%0d exp=9", fill_count);
        end
        cycle(1'b1, 1'b1, 1'b0, 8'h77);
        checks++;
        if (fill_count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset got cnt=%0d empty=%b ae=%b exp=0/1/1",
                     fill_count, empty, almost_empty);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_err got=%b/%b exp=0/0", overflow, underflow);
        end
`endif
        cycle(1'b0, 1'b1, 1'b0, 8'h33);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (read_data !== 8'h33 || read_valid !== 1'b1 || empty !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_rw got=%h/%b/%b exp=33/1/1", read_data,
                     read_valid, empty);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        int n;
        for (int i = 0; i < 600; i++) begin
            n = q.size();
            cycle(1'b0, ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35)),
                  ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70)),
                  DW'($urandom));
            checks++;
            if (read_valid !== m_rv || read_data !== m_rd
                || fill_count !== 5'(q.size())
                || full !== (q.size() == DEPTH) || empty !== (q.size() == 0)
                || almost_full !== (q.size() >= AF)
                || almost_empty !== (q.size() <= AE)) begin
                failures++;
                bad++;
                if (bad < 10)
                    $display("FAIL random[%0d] got rd=%h rv=%b cnt=%0d exp rd=%h rv=%b cnt=%0d prev=%0d",
                             i, read_data, read_valid, fill_count, m_rd, m_rv,
                             q.size(), n);
            end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            checks++;
            if (overflow !== m_ovf || underflow !== m_unf) begin
                failures++;
                $display("FAIL random_err[%0d] got=%b/%b exp=%b/%b", i,
                         overflow, underflow, m_ovf, m_unf);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_empty_rw();
        test_mid_reset();
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
